// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the byte-serial wide ALU
// and its 8-bit slice.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUBAB = 3'b001,
        OP_SUBBA = 3'b010,
        OP_OR    = 3'b011,
        OP_AND   = 3'b100,
        OP_ANDN  = 3'b101,
        OP_XOR   = 3'b110,
        OP_XNOR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUBAB) || (op == OP_SUBBA);
    endfunction

endpackage

// File: rtl/ALU.sv
// Team 8-bit ALU slice: combinational, carry-in/carry-out for the
// arithmetic opcodes, carry-out forced low for logic opcodes.
module ALU
    import alu_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    input  op_e        i_oper,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_res;

    always_comb begin
        w_res = '0;
        unique case (i_oper)
            OP_ADD:   w_res = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
            OP_SUBAB: w_res = {1'b0, i_a} + {1'b0, ~i_b} + {8'd0, i_cin};
            OP_SUBBA: w_res = {1'b0, i_b} + {1'b0, ~i_a} + {8'd0, ~i_cin};
            OP_OR:    w_res = {1'b0, i_a | i_b};
            OP_AND:   w_res = {1'b0, i_a & i_b};
            OP_ANDN:  w_res = {1'b0, ~i_a & i_b};
            OP_XOR:   w_res = {1'b0, i_a ^ i_b};
            OP_XNOR:  w_res = {1'b0, ~(i_a ^ i_b)};
        endcase
    end

    assign o_sum  = w_res[7:0];
    assign o_cout = w_res[8];

endmodule

// File: rtl/alu_wide_seq.sv
// Byte-serial wide ALU: one 8-bit slice per cycle, LSB first, then a
// commit cycle that publishes the result and holds it until taken.
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_oper,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_zero,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);

    state_e         r_state;
    state_e         w_next;
    logic [CW-1:0]  r_cnt;
    op_e            r_oper;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_sum;
    logic           r_cin;
    logic           r_carry;
    logic           r_cout;

    logic [7:0]     w_slice_sum;
    logic           w_slice_cout;
    logic           w_slice_cin;
    logic           w_accept;
    logic           w_commit;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_commit = (r_state == ST_EXEC) && (r_cnt == CW'(NBYTES));

    // b-a chains through an inverted carry so the slice sees ~borrow
    always_comb begin
        w_slice_cin = r_carry;
        if (r_cnt == '0)
            w_slice_cin = r_cin;
        else if (r_oper == OP_SUBBA)
            w_slice_cin = ~r_carry;
    end

    ALU u_alu (
        .i_a    (r_a[7:0]),
        .i_b    (r_b[7:0]),
        .i_cin  (w_slice_cin),
        .i_oper (r_oper),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (req_valid) w_next = ST_EXEC;
            ST_EXEC: if (w_commit)  w_next = ST_DONE;
            ST_DONE: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
    end

    // operands shift right so the slice always reads byte 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_oper  <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_oper  <= op_e'(req_oper);
            r_a     <= req_a;
            r_b     <= req_b;
            r_acc   <= '0;
            r_cin   <= req_cin;
            r_carry <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if (w_commit) begin
                r_sum  <= r_acc;
                r_cout <= is_arith(r_oper) & r_carry;
            end else begin
                r_a     <= r_a >> 8;
                r_b     <= r_b >> 8;
                r_acc   <= {w_slice_sum, r_acc[W-1:8]};
                r_carry <= w_slice_cout;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;
    assign rsp_zero = (r_sum == '0);

endmodule

// File: tb/tb_alu_wide_seq.sv
// Scoreboard bench for alu_wide_seq: directed corner cases plus
// randomized traffic against a full-width arithmetic model.
module tb_alu_wide_seq;
    import alu_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_oper = 3'd0;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          req_cin = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_sum;
    logic          rsp_cout;
    logic          rsp_zero;
    logic          busy;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_oper  (req_oper),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   bp_mode = 2;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [W:0] model(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
        logic [W:0] r;
        r = '0;
        case (op)
            OP_ADD:   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            OP_SUBAB: r = {1'b0, a} + {1'b0, ~b} + (W+1)'(c);
            OP_SUBBA: r = {1'b0, b} + {1'b0, ~a} + (W+1)'(!c);
            OP_OR:    r = {1'b0, a | b};
            OP_AND:   r = {1'b0, a & b};
            OP_ANDN:  r = {1'b0, ~a & b};
            OP_XOR:   r = {1'b0, a ^ b};
            default:  r = {1'b0, ~(a ^ b)};
        endcase
        return r;
    endfunction

    always begin
        @(posedge clk);
        #2;
        if (bp_mode == 1)      rsp_ready = 1'b0;
        else if (bp_mode == 2) rsp_ready = 1'b1;
        else                   rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        int n;
        logic [W:0] r;
        exp_t e;
        n = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_oper  = op;
        req_a     = a;
        req_b     = b;
        req_cin   = c;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", 64'(n), 64'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        r = model(op, a, b, c);
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.acc  = cyc;
        exp_q.push_back(e);
        req_valid = 1'b0;
        req_oper  = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        req_cin   = 1'($urandom);
    endtask

    logic         prev_valid = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_zero;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("req_ready_in_done", 64'(req_ready), 64'd0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                        chk("rsp_zero", 64'(rsp_zero), 64'(e.sum == '0));
                        chk("latency", 64'(cyc - e.acc), 64'(NB + 1));
                    end
                    held_sum  = rsp_sum;
                    held_cout = rsp_cout;
                    held_zero = rsp_zero;
                end else begin
                    chk("stable_sum", 64'(rsp_sum), 64'(held_sum));
                    chk("stable_cout", 64'(rsp_cout), 64'(held_cout));
                    chk("stable_zero", 64'(rsp_zero), 64'(held_zero));
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_sum", 64'(rsp_sum), 64'd0);
        chk("rst_cout", 64'(rsp_cout), 64'd0);
        chk("rst_zero", 64'(rsp_zero), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        issue(OP_ADD,   32'h0000_00FF, 32'h0000_0001, 1'b0);
        issue(OP_ADD,   32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        issue(OP_SUBAB, 32'h0001_0000, 32'h0000_0001, 1'b1);
        issue(OP_SUBBA, 32'h0000_0001, 32'h0000_0000, 1'b0);
        issue(OP_XNOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        drain();

        bp_mode = 0;
        for (int i = 0; i < 40; i++)
            issue(3'($urandom), $urandom, $urandom, 1'($urandom));
        drain();

        bp_mode = 1;
        issue(OP_SUBAB, 32'h1234_5678, 32'h8765_4321, 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_a     = $urandom;
            req_b     = $urandom;
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_busy", 64'(busy), 64'd1);
        end
        req_valid = 1'b0;
        bp_mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_idle", 64'(req_ready), 64'd1);
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        drain();

        issue(OP_ADD, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        issue(OP_SUBBA, 32'h0000_0010, 32'h0000_0100, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
